iter_alu: RTL

- Execute-stage ALU that consumes the 5-bit ALU control code produced by the core's ALU control unit, with a valid/ready handshake on both sides.
- Add, sub, logic and compare operations complete in one cycle. Shifts run iteratively, one bit per cycle, to save area on the MPW core.
- Sits between decode/issue and writeback. It also supplies zero/compare results for branch resolution.

---
 rtl/iter_alu.sv | 131 +++++++++++++
 1 files changed

// File: rtl/iter_alu.sv
// Execute-stage ALU with valid/ready handshakes. Add/sub/logic/compare finish in
// one cycle; shifts move one bit per cycle through a dedicated shift register.
module iter_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b00110;
  localparam logic [4:0] OP_SUB  = 5'b10000;
  localparam logic [4:0] OP_SLTU = 5'b11000;
  localparam logic [4:0] OP_SLT  = 5'b10111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg;
  logic            valid_reg;
  logic [XLEN-1:0] result_reg;
  logic [XLEN-1:0] shift_reg;
  logic [SHW-1:0]  cnt_reg;
  logic            left_reg;
  logic            arith_reg;

  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shift_step;
  logic [SHW-1:0]  shamt;
  logic            is_shift;

  assign shamt    = op_b_i[SHW-1:0];
  assign is_shift = (alu_ctrl_i == OP_SLL) || (alu_ctrl_i == OP_SRL) ||
                    (alu_ctrl_i == OP_SRA);

  // Single-cycle results; a shift by zero simply passes operand A through.
  always_comb begin
    alu_res = op_a_i + op_b_i;
    case (alu_ctrl_i)
      OP_AND:  alu_res = op_a_i & op_b_i;
      OP_OR:   alu_res = op_a_i | op_b_i;
      OP_XOR:  alu_res = op_a_i ^ op_b_i;
      OP_SUB:  alu_res = op_a_i - op_b_i;
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a_i;
      default: alu_res = op_a_i + op_b_i;
    endcase
  end

  always_comb begin
    if (left_reg)
      shift_step = {shift_reg[XLEN-2:0], 1'b0};
    else
      shift_step = {arith_reg & shift_reg[XLEN-1], shift_reg[XLEN-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      valid_reg  <= 1'b0;
      result_reg <= '0;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      left_reg   <= 1'b0;
      arith_reg  <= 1'b0;
    end else if (kill_i) begin
      // Flush wins over everything, including a pending ready_i in DONE.
      state_reg <= IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            if (is_shift && (shamt != '0)) begin
              shift_reg <= op_a_i;
              cnt_reg   <= shamt;
              left_reg  <= (alu_ctrl_i == OP_SLL);
              arith_reg <= (alu_ctrl_i == OP_SRA);
              state_reg <= SHIFT;
            end else begin
              result_reg <= alu_res;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end
          end
        end
        SHIFT: begin
          shift_reg <= shift_step;
          cnt_reg   <= cnt_reg - 1'b1;
          if (cnt_reg == SHW'(1)) begin
            result_reg <= shift_step;
            valid_reg  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready_o  = (state_reg == IDLE);
  assign valid_o  = valid_reg;
  assign result_o = result_reg;
  assign zero_o   = (result_reg == '0);

endmodule
